// File: rtl/cmos_pkg.sv
// Shared types and constants for the DVP camera capture block.
package cmos_pkg;

  localparam int unsigned Rgb565Width = 16;

  typedef enum logic [1:0] {
    StSkip   = 2'd0,
    StWaitFs = 2'd1,
    StActive = 2'd2
  } state_e;

endpackage

// File: rtl/dvp_sync_edge.sv
// Registers the camera vsync/href strobes once and flags their edges on the registered copies.
module dvp_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic href_s,
  output logic vsync_fall,
  output logic vsync_rise,
  output logic href_fall
);

  logic vsync_q, vsync_qq;
  logic href_q, href_qq;

  // Both stages clear on reset so no edge is seen on the first cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      href_q   <= href;
      href_qq  <= href_q;
    end
  end

  always_comb begin
    href_s     = href_q;
    vsync_fall = vsync_qq & ~vsync_q;
    vsync_rise = ~vsync_qq & vsync_q;
    href_fall  = href_qq & ~href_q;
  end

endmodule

// File: rtl/cmos_dvp_capture.sv
// DVP camera capture: skips start-up frames, pairs bytes into RGB565 pixels and
// flags line/frame format errors.
module cmos_dvp_capture
  import cmos_pkg::*;
#(
  parameter int unsigned H_PIXELS    = 640,
  parameter int unsigned V_LINES     = 480,
  parameter int unsigned SKIP_FRAMES = 10
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cam_vsync,
  input  logic                   cam_href,
  input  logic [7:0]             cam_data,
  output logic [Rgb565Width-1:0] pix_data,
  output logic                   pix_valid,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic                   frame_done,
  output logic                   err
);

  localparam int unsigned PixW  = $clog2(H_PIXELS + 1);
  localparam int unsigned LineW = $clog2(V_LINES + 1);
  localparam int unsigned SkipW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

  localparam logic [PixW-1:0]  HMax     = PixW'(H_PIXELS);
  localparam logic [PixW-1:0]  HLast    = PixW'(H_PIXELS - 1);
  localparam logic [LineW-1:0] VMax     = LineW'(V_LINES);
  localparam logic [SkipW-1:0] SkipLast = SkipW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

  logic       href_s, vs_fall, vs_rise, href_fall;
  logic [7:0] data_s;

  dvp_sync_edge u_sync_edge (
    .clk        (clkin),
    .rst        (reset),
    .vsync      (cam_vsync),
    .href       (cam_href),
    .href_s     (href_s),
    .vsync_fall (vs_fall),
    .vsync_rise (vs_rise),
    .href_fall  (href_fall)
  );

  state_e                  state_q, state_d;
  logic [SkipW-1:0]        skip_cnt_q, skip_cnt_d;
  logic [PixW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [LineW-1:0]        line_cnt_q, line_cnt_d;
  logic                    phase_q, phase_d;
  logic [7:0]              hi_byte_q, hi_byte_d;
  logic                    frame_err_q, frame_err_d;
  logic                    err_d;
  logic [Rgb565Width-1:0]  pix_data_d;
  logic                    pix_valid_d, pix_sof_d, pix_eol_d, frame_done_d;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= StSkip;
      data_s      <= '0;
      skip_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      phase_q     <= 1'b0;
      hi_byte_q   <= '0;
      frame_err_q <= 1'b0;
      err         <= 1'b0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_s      <= cam_data;
      skip_cnt_q  <= skip_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      phase_q     <= phase_d;
      hi_byte_q   <= hi_byte_d;
      frame_err_q <= frame_err_d;
      err         <= err_d;
      pix_data    <= pix_data_d;
      pix_valid   <= pix_valid_d;
      pix_sof     <= pix_sof_d;
      pix_eol     <= pix_eol_d;
      frame_done  <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    phase_d      = phase_q;
    hi_byte_d    = hi_byte_q;
    frame_err_d  = frame_err_q;
    err_d        = err;
    pix_data_d   = pix_data;
    pix_valid_d  = 1'b0;
    pix_sof_d    = 1'b0;
    pix_eol_d    = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      StSkip: begin
        if (SKIP_FRAMES == 0) begin
          state_d = StWaitFs;
        end else if (vs_fall) begin
          if (skip_cnt_q == SkipLast) begin
            state_d = StWaitFs;
          end else begin
            skip_cnt_d = skip_cnt_q + 1'b1;
          end
        end
      end

      StWaitFs: begin
        if (vs_fall && enable) begin
          state_d     = StActive;
          pix_cnt_d   = '0;
          line_cnt_d  = '0;
          phase_d     = 1'b0;
          frame_err_d = 1'b0;
        end
      end

      StActive: begin
        if (vs_fall) begin
          // Frame start without a frame end: restart at line 0, frame is already tainted.
          err_d       = 1'b1;
          frame_err_d = 1'b1;
          pix_cnt_d   = '0;
          line_cnt_d  = '0;
          phase_d     = 1'b0;
        end else if (vs_rise && !href_s) begin
          // A vsync rise during an active line is treated as a glitch, not a frame end.
          frame_done_d = (line_cnt_q == VMax) && !frame_err_q;
          state_d      = StWaitFs;
        end else if (href_s) begin
          if (!phase_q) begin
            hi_byte_d = data_s;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (line_cnt_q == VMax || pix_cnt_q == HMax) begin
              err_d       = 1'b1;
              frame_err_d = 1'b1;
            end else begin
              pix_data_d  = {hi_byte_q, data_s};
              pix_valid_d = 1'b1;
              pix_sof_d   = (line_cnt_q == '0) && (pix_cnt_q == '0);
              pix_eol_d   = (pix_cnt_q == HLast);
              pix_cnt_d   = pix_cnt_q + 1'b1;
            end
          end
        end else if (href_fall) begin
          if (phase_q || pix_cnt_q != HMax) begin
            err_d       = 1'b1;
            frame_err_d = 1'b1;
          end
          phase_d   = 1'b0;
          pix_cnt_d = '0;
          if (line_cnt_q != VMax) begin
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StSkip;
    endcase
  end

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// Scoreboard bench for cmos_dvp_capture with H=4, V=2, SKIP=1 and directed byte streams.
module tb_cmos_dvp_capture;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } pix_t;

  logic        clkin = 1'b0;
  logic        reset, enable, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic [15:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol, frame_done, err;

  int   checks   = 0;
  int   failures = 0;
  int   exp_done = 0;
  pix_t exp_q[$];
  pix_t mon_e;

  always #5 clkin = ~clkin;

  cmos_dvp_capture #(
    .H_PIXELS    (4),
    .V_LINES     (2),
    .SKIP_FRAMES (1)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .enable     (enable),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .frame_done (frame_done),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel or frame_done.
  always @(negedge clkin) begin
    if (pix_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel actual=%h required=none", pix_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel{data,sof,eol}", 32'({pix_data, pix_sof, pix_eol}), 32'(mon_e));
      end
    end
    if (frame_done) begin
      checks++;
      if (exp_done > 0) begin
        exp_done--;
      end else begin
        failures++;
        $display("FAIL unexpected_frame_done actual=1 required=0");
      end
    end
  end

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clkin);
    #2;
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(cam_vsync, 1'b0, 8'h00);
  endtask

  task automatic line_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, base + 8'(i));
    idle(3);
  endtask

  task automatic frame_begin();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic full_frame(input logic [7:0] b0, input logic [7:0] b1);
    frame_begin();
    line_bytes(b0, 8);
    line_bytes(b1, 8);
    frame_end();
  endtask

  task automatic push(input logic [15:0] d, input logic sof, input logic eol);
    exp_q.push_back('{data: d, sof: sof, eol: eol});
  endtask

  // Four pixels from eight consecutive bytes starting at base.
  task automatic exp_line(input logic [7:0] base, input logic first);
    logic [7:0] lo;
    for (int i = 0; i < 4; i++) begin
      lo = base + 8'(2 * i);
      push({lo, lo + 8'd1}, first && (i == 0), i == 3);
    end
  endtask

  task automatic scen_end(input string name, input logic req_err);
    idle(10);
    check({name, "_pixels_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_done_seen"}, 32'(exp_done), 32'd0);
    check({name, "_err"}, 32'(err), 32'(req_err));
  endtask

  task automatic do_reset();
    @(posedge clkin);
    #2;
    reset     = 1'b1;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    @(negedge clkin);
    check("reset_outputs_zero",
          32'({pix_data, pix_valid, pix_sof, pix_eol, frame_done, err}), 32'd0);
    repeat (3) @(posedge clkin);
    #2;
    reset = 1'b0;
    idle(4);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    repeat (3) @(negedge clkin);
    check("initial_reset_outputs_zero",
          32'({pix_data, pix_valid, pix_sof, pix_eol, frame_done, err}), 32'd0);
    @(posedge clkin);
    #2;
    reset = 1'b0;
    idle(4);

    // Two clean frames: the first is skipped, the second is captured.
    full_frame(8'h00, 8'h08);
    exp_line(8'h00, 1'b1);
    exp_line(8'h08, 1'b0);
    exp_done++;
    full_frame(8'h00, 8'h08);
    scen_end("clean_frames", 1'b0);

    // Enable dropped mid-frame: frame completes, the next one is not captured.
    exp_line(8'h40, 1'b1);
    exp_line(8'h48, 1'b0);
    exp_done++;
    frame_begin();
    line_bytes(8'h40, 8);
    enable = 1'b0;
    line_bytes(8'h48, 8);
    frame_end();
    full_frame(8'h58, 8'h60);
    enable = 1'b1;
    scen_end("enable_drop", 1'b0);

    // Odd byte count: three pixels, trailing byte discarded, no frame_done.
    push(16'h2021, 1'b1, 1'b0);
    push(16'h2223, 1'b0, 1'b0);
    push(16'h2425, 1'b0, 1'b0);
    exp_line(8'h30, 1'b0);
    frame_begin();
    line_bytes(8'h20, 7);
    line_bytes(8'h30, 8);
    frame_end();
    scen_end("odd_bytes", 1'b1);

    // Reset after three bytes of a line, then one skipped frame.
    frame_begin();
    drive(1'b0, 1'b1, 8'h50);
    drive(1'b0, 1'b1, 8'h51);
    drive(1'b0, 1'b1, 8'h52);
    do_reset();
    full_frame(8'h60, 8'h68);
    scen_end("post_reset_skip", 1'b0);

    // Ten-byte line: fifth pixel dropped.
    exp_line(8'h70, 1'b1);
    exp_line(8'h80, 1'b0);
    frame_begin();
    line_bytes(8'h70, 10);
    line_bytes(8'h80, 8);
    frame_end();
    scen_end("long_line", 1'b1);

    // Second frame start during a line: frame restarts at line 0.
    do_reset();
    full_frame(8'hf0, 8'hf8);
    exp_line(8'h90, 1'b1);
    push(16'ha0a1, 1'b0, 1'b0);
    exp_line(8'hb0, 1'b1);
    exp_line(8'hc0, 1'b0);
    frame_begin();
    line_bytes(8'h90, 8);
    drive(1'b0, 1'b1, 8'ha0);
    drive(1'b0, 1'b1, 8'ha1);
    drive(1'b1, 1'b1, 8'ha2);
    drive(1'b0, 1'b1, 8'ha3);
    line_bytes(8'hb0, 8);
    line_bytes(8'hc0, 8);
    frame_end();
    scen_end("double_frame_start", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
